stream_cipher_arbiter: RTL and testbench
========================================

// Module: stream_cipher_arbiter
// PURPOSE
//  Shares one aes_sbox_stream_cipher instance between two byte-stream requesters (ch0, ch1).
//  Each channel supplies its own plaintext/ciphertext byte and 8-bit key per byte.
//  Round-robin burst arbitration: registers the winning byte/key into the cipher and keeps
//  an in-flight channel-tag FIFO, so every cipher output is returned tagged with its source.
// PARAMETERS
//  BURST_MAX  4  max bytes accepted from one channel per grant while the other channel waits (>=1)
//  TAG_DEPTH  4  in-flight tag FIFO depth; must be >= cipher latency + 2 (power of 2)
// PORTS
//  clk             in   1  clock
//  rst_n           in   1  asynchronous active-low reset
//  ch0_valid       in   1  ch0 byte available
//  ch0_char        in   8  ch0 input byte
//  ch0_key         in   8  ch0 key for this byte
//  ch0_ready       out  1  ch0 byte accepted this cycle when ch0_valid & ch0_ready
//  ch1_valid/ch1_char/ch1_key/ch1_ready     same as ch0, for ch1
//  cph_din_valid   out  1  to cipher din_valid
//  cph_key         out  8  to cipher simmetric_key
//  cph_char        out  8  to cipher txt_in_char
//  cph_dout        in   8  from cipher txt_out_char
//  cph_dout_ready  in   1  from cipher dout_ready
//  out_valid       out  1  tagged result valid (single-cycle pulse per byte, no backpressure)
//  out_char        out  8  result byte
//  out_ch          out  1  source channel of out_char
//  busy            out  1  state != IDLE or tag FIFO non-empty
//  err_tag         out  1  sticky: cph_dout_ready seen with tag FIFO empty
// BEHAVIOUR
//  Reset: state=IDLE, last=1 (ch0 wins first tie), burst_cnt=0, tag FIFO empty;
//   all outputs 0. Reset mid-operation discards in-flight tags; no out_valid until new issue.
//  FSM states IDLE, GNT0, GNT1. chX_ready = (state==GNTx) & !tag_full (combinational).
//  IDLE: both valid -> GNT of channel != last; one valid -> its GNT; none -> stay. No accept in IDLE.
//  GNTx, accept this cycle: burst_cnt++; if burst_cnt==BURST_MAX-1 and other valid -> GNT other, cnt=0.
//  GNTx, chX_valid=0: other valid -> GNT other; else -> IDLE. cnt=0 on any state change.
//  On entering GNTx, last<=x. tag_full stalls accept but does not change state.
//  Issue: accept at cycle N -> cph_din_valid=1, cph_char/cph_key=accepted values at cycle N+1;
//   tag x pushed at N. cph_din_valid=0 on non-accept cycles; cph_char/cph_key hold last value.
//  Return: cph_dout_ready at cycle M -> pop tag; out_valid=1, out_char=cph_dout, out_ch=tag at M+1.
//  Push and pop in same cycle: count unchanged, order preserved (FIFO, pointers wrap mod TAG_DEPTH).
//  Pop on empty: no pointer change, out_valid=0, err_tag<=1 (cleared only by reset).
//  Outputs in acceptance order; per-channel order preserved; key never mixed between channels.
// TESTING
//  ch0 only sends 'A','B','C' key 0x12 -> cph_din_valid 3 consecutive cycles, 3 out_valid, out_ch=0.
//  ch0,ch1 both continuously valid, BURST_MAX=4 -> accepts 0,0,0,0,1,1,1,1,0,... out_ch matches.
//  ch1 key 0x12 / ch0 key 0x34 interleaved -> cph_key follows grant per byte; each channel's decrypt matches.
//  Stub cipher holds cph_dout_ready=0 -> exactly TAG_DEPTH accepts, then chX_ready=0 until pop.
//  rst_n low mid-burst with 2 bytes in flight -> all outputs 0, busy=0; later stray dout_ready sets err_tag.
//  Simultaneous push/pop at tag_full-1 for 20 cycles -> no stall, no loss, err_tag stays 0.

Source files
------------

// File: rtl/stream_cipher_arbiter.sv
// ---------------------------------------------------------------------------
// stream_cipher_arbiter
//   Shares one byte-stream cipher between two requesters (ch0, ch1) using
//   round-robin burst arbitration. The winning byte/key pair is registered
//   toward the cipher. A small in-flight FIFO records the source channel of
//   every issued byte, so each cipher result is returned tagged with its
//   originating channel.
//
// Parameters
//   BURST_MAX  max bytes accepted from one channel per grant while the other
//              channel is waiting (>= 1)
//   TAG_DEPTH  in-flight tag FIFO depth, power of 2, >= cipher latency + 2
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   chX_valid/chX_char/chX_key     requester byte, key and valid (X = 0, 1)
//   chX_ready                      byte accepted when chX_valid & chX_ready
//   cph_din_valid/cph_key/cph_char registered request toward the cipher
//   cph_dout/cph_dout_ready        cipher result and its strobe
//   out_valid/out_char/out_ch      tagged result (one-cycle pulse per byte)
//   busy                           arbiter granted or results still in flight
//   err_tag                        sticky: cipher result arrived with no tag
// ---------------------------------------------------------------------------
module stream_cipher_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ch0_valid,
  input  logic [7:0] ch0_char,
  input  logic [7:0] ch0_key,
  output logic       ch0_ready,
  input  logic       ch1_valid,
  input  logic [7:0] ch1_char,
  input  logic [7:0] ch1_key,
  output logic       ch1_ready,
  output logic       cph_din_valid,
  output logic [7:0] cph_key,
  output logic [7:0] cph_char,
  input  logic [7:0] cph_dout,
  input  logic       cph_dout_ready,
  output logic       out_valid,
  output logic [7:0] out_char,
  output logic       out_ch,
  output logic       busy,
  output logic       err_tag
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(BURST_MAX) + 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(TAG_DEPTH);
  localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          tag_mem_q [TAG_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;

  logic          din_valid_q;
  logic [7:0]    din_char_q, din_key_q;
  logic          out_valid_q, out_ch_q, err_tag_q;
  logic [7:0]    out_char_q;

  logic tag_full, tag_empty, acc0, acc1, accept, pop;

  assign tag_full  = (count_q == FULL_CNT);
  assign tag_empty = (count_q == '0);
  assign ch0_ready = (state_q == GNT0) && !tag_full;
  assign ch1_ready = (state_q == GNT1) && !tag_full;
  assign acc0      = ch0_valid && ch0_ready;
  assign acc1      = ch1_valid && ch1_ready;
  assign accept    = acc0 || acc1;
  assign pop       = cph_dout_ready && !tag_empty;

  // Arbitration. The burst counter saturates at BURST_MAX-1 so that a
  // channel which kept streaming alone still yields on its next accept once
  // the other channel shows up.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ch0_valid && ch1_valid) state_d = last_q ? GNT0 : GNT1;
        else if (ch0_valid)         state_d = GNT0;
        else if (ch1_valid)         state_d = GNT1;
      end
      GNT0: begin
        if (!ch0_valid) begin
          state_d = ch1_valid ? GNT1 : IDLE;
        end else if (acc0) begin
          if (cnt_q >= BURST_LAST && ch1_valid) state_d = GNT1;
          else if (cnt_q < BURST_LAST)          cnt_d   = cnt_q + CW'(1);
        end
      end
      GNT1: begin
        if (!ch1_valid) begin
          state_d = ch0_valid ? GNT0 : IDLE;
        end else if (acc1) begin
          if (cnt_q >= BURST_LAST && ch0_valid) state_d = GNT0;
          else if (cnt_q < BURST_LAST)          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == GNT0)      last_d = 1'b0;
      else if (state_d == GNT1) last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // In-flight tag FIFO: push the granted channel on accept, pop on each
  // cipher result. A result with no outstanding tag is flagged, not popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= 1'b0;
    end else begin
      if (accept) begin
        tag_mem_q[wr_ptr_q] <= acc1;
        wr_ptr_q            <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Cipher request and tagged result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_valid_q <= 1'b0;
      din_char_q  <= '0;
      din_key_q   <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      out_ch_q    <= 1'b0;
      err_tag_q   <= 1'b0;
    end else begin
      din_valid_q <= accept;
      if (accept) begin
        din_char_q <= acc1 ? ch1_char : ch0_char;
        din_key_q  <= acc1 ? ch1_key  : ch0_key;
      end
      out_valid_q <= pop;
      if (pop) begin
        out_char_q <= cph_dout;
        out_ch_q   <= tag_mem_q[rd_ptr_q];
      end
      if (cph_dout_ready && tag_empty) err_tag_q <= 1'b1;
    end
  end

  assign cph_din_valid = din_valid_q;
  assign cph_char      = din_char_q;
  assign cph_key       = din_key_q;
  assign out_valid     = out_valid_q;
  assign out_char      = out_char_q;
  assign out_ch        = out_ch_q;
  assign err_tag       = err_tag_q;
  assign busy          = (state_q != IDLE) || !tag_empty;

endmodule

// File: tb/tb_stream_cipher_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_cipher_arbiter
//   Self-checking bench for stream_cipher_arbiter. A stub cipher returns
//   char ^ key, optionally stalled or randomly throttled. Sources are byte
//   queues per channel; accepted bytes, issued requests and tagged results
//   are logged and compared with what the sources sent.
// ---------------------------------------------------------------------------
module tb_stream_cipher_arbiter;
  localparam int BURST_MAX = 4;
  localparam int TAG_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ch0_valid, ch1_valid, ch0_ready, ch1_ready;
  logic [7:0] ch0_char, ch0_key, ch1_char, ch1_key;
  logic       cph_din_valid, cph_dout_ready;
  logic [7:0] cph_key, cph_char, cph_dout;
  logic       out_valid, out_ch, busy, err_tag;
  logic [7:0] out_char;

  always #5 clk = ~clk;

  stream_cipher_arbiter #(.BURST_MAX(BURST_MAX), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_valid(ch0_valid), .ch0_char(ch0_char), .ch0_key(ch0_key), .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid), .ch1_char(ch1_char), .ch1_key(ch1_key), .ch1_ready(ch1_ready),
    .cph_din_valid(cph_din_valid), .cph_key(cph_key), .cph_char(cph_char),
    .cph_dout(cph_dout), .cph_dout_ready(cph_dout_ready),
    .out_valid(out_valid), .out_char(out_char), .out_ch(out_ch),
    .busy(busy), .err_tag(err_tag)
  );

  typedef struct packed {
    logic       ch;
    logic [7:0] chr;
    logic [7:0] key;
  } byte_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          acc_cnt  = 0;
  byte_t       src0[$], src1[$], acc_log[$];
  logic [15:0] issue_log[$];
  int          issue_cyc[$];
  logic [8:0]  out_log[$];
  logic [7:0]  stub_q[$];
  bit          stub_en, stub_rand, gap_en, stray, pend0, pend1;

  function automatic byte_t mk(input logic ch, input logic [7:0] c, input logic [7:0] k);
    byte_t b;
    b.ch = ch; b.chr = c; b.key = k;
    return b;
  endfunction

  task automatic clear_tb();
    src0.delete(); src1.delete(); acc_log.delete(); issue_log.delete();
    issue_cyc.delete(); out_log.delete(); stub_q.delete();
    pend0 = 0; pend1 = 0; stray = 0; acc_cnt = 0;
    ch0_valid = 0; ch1_valid = 0; cph_dout_ready = 0; cph_dout = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_tb();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: observe at the falling edge, then drive for the next rise.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (out_valid) out_log.push_back({out_ch, out_char});
    if (cph_din_valid) begin
      issue_log.push_back({cph_char, cph_key});
      issue_cyc.push_back(cyc);
      stub_q.push_back(cph_char ^ cph_key);
    end
    if (pend0) begin acc_log.push_back(src0.pop_front()); acc_cnt++; end
    if (pend1) begin acc_log.push_back(src1.pop_front()); acc_cnt++; end
    if (stray) begin
      cph_dout_ready = 1'b1; cph_dout = 8'h55;
    end else if (stub_en && stub_q.size() > 0 && (!stub_rand || $urandom_range(0, 3) != 0)) begin
      cph_dout_ready = 1'b1; cph_dout = stub_q.pop_front();
    end else begin
      cph_dout_ready = 1'b0;
    end
    ch0_valid = (src0.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    ch1_valid = (src1.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    if (src0.size() > 0) begin ch0_char = src0[0].chr; ch0_key = src0[0].key; end
    if (src1.size() > 0) begin ch1_char = src1[0].chr; ch1_key = src1[0].key; end
    pend0 = ch0_valid && ch0_ready;
    pend1 = ch1_valid && ch1_ready;
  endtask

  task automatic run_until_out(input int n, input int bound);
    for (int k = 0; k < bound && out_log.size() < n; k++) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_tb();
    @(negedge clk); #1;
    n_checks++;
    if ({ch0_ready, ch1_ready, cph_din_valid, out_valid, out_ch, busy, err_tag} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000",
               {ch0_ready, ch1_ready, cph_din_valid, out_valid, out_ch, busy, err_tag});
    else n_pass++;
    n_checks++;
    if ({cph_key, cph_char, out_char} !== 24'h0)
      $display("FAIL reset_data: got %h want 000000", {cph_key, cph_char, out_char});
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if ({busy, ch0_ready, ch1_ready, err_tag} !== 4'b0)
      $display("FAIL reset_idle: got %b want 0000", {busy, ch0_ready, ch1_ready, err_tag});
    else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] txt [3];
    txt[0] = "A"; txt[1] = "B"; txt[2] = "C";
    do_reset();
    stub_en = 1; stub_rand = 0; gap_en = 0;
    for (int i = 0; i < 3; i++) src0.push_back(mk(1'b0, txt[i], 8'h12));
    run_until_out(3, 40);
    repeat (3) cycle();
    n_checks++;
    if (issue_log.size() != 3) $display("FAIL single_issue_cnt: got %0d want 3", issue_log.size());
    else n_pass++;
    for (int i = 1; i < issue_cyc.size(); i++) begin
      n_checks++;
      if (issue_cyc[i] != issue_cyc[i-1] + 1)
        $display("FAIL single_consec[%0d]: got cycle %0d want %0d", i, issue_cyc[i], issue_cyc[i-1] + 1);
      else n_pass++;
    end
    for (int i = 0; i < 3 && i < issue_log.size(); i++) begin
      n_checks++;
      if (issue_log[i] !== {txt[i], 8'h12})
        $display("FAIL single_issue[%0d]: got %h want %h", i, issue_log[i], {txt[i], 8'h12});
      else n_pass++;
    end
    n_checks++;
    if (out_log.size() != 3) $display("FAIL single_out_cnt: got %0d want 3", out_log.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < out_log.size(); i++) begin
      n_checks++;
      if (out_log[i] !== {1'b0, txt[i] ^ 8'h12})
        $display("FAIL single_out[%0d]: got %h want %h", i, out_log[i], {1'b0, txt[i] ^ 8'h12});
      else n_pass++;
    end
    n_checks++;
    if ({busy, err_tag} !== 2'b00) $display("FAIL single_idle: got busy/err %b want 00", {busy, err_tag});
    else n_pass++;
  endtask

  task automatic test_burst();
    do_reset();
    stub_en = 1; stub_rand = 0; gap_en = 0;
    for (int i = 0; i < 12; i++) begin
      src0.push_back(mk(1'b0, 8'($urandom), 8'h34));
      src1.push_back(mk(1'b1, 8'($urandom), 8'h12));
    end
    run_until_out(24, 200);
    n_checks++;
    if (acc_log.size() != 24) $display("FAIL burst_acc_cnt: got %0d want 24", acc_log.size());
    else n_pass++;
    for (int i = 0; i < acc_log.size(); i++) begin
      n_checks++;
      if (acc_log[i].ch !== 1'((i / BURST_MAX) % 2))
        $display("FAIL burst_grant[%0d]: got ch%0d want ch%0d", i, acc_log[i].ch, (i / BURST_MAX) % 2);
      else n_pass++;
    end
    for (int i = 0; i < out_log.size() && i < acc_log.size(); i++) begin
      n_checks++;
      if (out_log[i] !== {acc_log[i].ch, acc_log[i].chr ^ acc_log[i].key})
        $display("FAIL burst_out[%0d]: got %h want %h", i, out_log[i],
                 {acc_log[i].ch, acc_log[i].chr ^ acc_log[i].key});
      else n_pass++;
    end
  endtask

  task automatic test_interleave_random();
    logic [7:0] sent0[$], sent1[$], got0[$], got1[$];
    int nerr_issue;
    do_reset();
    stub_en = 1; stub_rand = 1; gap_en = 1;
    for (int i = 0; i < 30; i++) begin
      src0.push_back(mk(1'b0, 8'($urandom), 8'h34)); sent0.push_back(src0[i].chr);
      src1.push_back(mk(1'b1, 8'($urandom), 8'h12)); sent1.push_back(src1[i].chr);
    end
    run_until_out(60, 2000);
    repeat (4) cycle();
    n_checks++;
    if (out_log.size() != 60) $display("FAIL rand_out_cnt: got %0d want 60", out_log.size());
    else n_pass++;
    foreach (out_log[i]) begin
      if (out_log[i][8]) got1.push_back(out_log[i][7:0] ^ 8'h12);
      else               got0.push_back(out_log[i][7:0] ^ 8'h34);
    end
    n_checks++;
    if (got0 != sent0) $display("FAIL rand_ch0_stream: got %0d bytes (order/data differ) want %0d", got0.size(), sent0.size());
    else n_pass++;
    n_checks++;
    if (got1 != sent1) $display("FAIL rand_ch1_stream: got %0d bytes (order/data differ) want %0d", got1.size(), sent1.size());
    else n_pass++;
    nerr_issue = 0;
    for (int i = 0; i < issue_log.size() && i < acc_log.size(); i++)
      if (issue_log[i] !== {acc_log[i].chr, acc_log[i].key}) nerr_issue++;
    n_checks++;
    if (nerr_issue != 0 || issue_log.size() != 60)
      $display("FAIL rand_issue_key: got %0d bad of %0d issues want 0 bad of 60", nerr_issue, issue_log.size());
    else n_pass++;
    for (int i = 0; i < out_log.size() && i < acc_log.size(); i++) begin
      n_checks++;
      if (out_log[i] !== {acc_log[i].ch, acc_log[i].chr ^ acc_log[i].key})
        $display("FAIL rand_out[%0d]: got %h want %h", i, out_log[i],
                 {acc_log[i].ch, acc_log[i].chr ^ acc_log[i].key});
      else n_pass++;
    end
    n_checks++;
    if ({busy, err_tag} !== 2'b00) $display("FAIL rand_idle: got busy/err %b want 00", {busy, err_tag});
    else n_pass++;
  endtask

  task automatic test_tag_full();
    do_reset();
    stub_en = 0; stub_rand = 0; gap_en = 0;
    for (int i = 0; i < 8; i++) src0.push_back(mk(1'b0, 8'($urandom), 8'h5a));
    repeat (12) cycle();
    n_checks++;
    if (acc_cnt != TAG_DEPTH) $display("FAIL full_acc_cnt: got %0d want %0d", acc_cnt, TAG_DEPTH);
    else n_pass++;
    n_checks++;
    if ({ch0_ready, busy} !== 2'b01) $display("FAIL full_stall: got ready/busy %b want 01", {ch0_ready, busy});
    else n_pass++;
    n_checks++;
    if (out_log.size() != 0) $display("FAIL full_no_out: got %0d want 0", out_log.size());
    else n_pass++;
    stub_en = 1;
    run_until_out(8, 100);
    n_checks++;
    if (out_log.size() != 8) $display("FAIL full_drain_cnt: got %0d want 8", out_log.size());
    else n_pass++;
    for (int i = 0; i < out_log.size() && i < acc_log.size(); i++) begin
      n_checks++;
      if (out_log[i] !== {1'b0, acc_log[i].chr ^ 8'h5a})
        $display("FAIL full_out[%0d]: got %h want %h", i, out_log[i], {1'b0, acc_log[i].chr ^ 8'h5a});
      else n_pass++;
    end
  endtask

  task automatic test_simul_push_pop();
    int base, stalls;
    do_reset();
    stub_en = 0; stub_rand = 0; gap_en = 0;
    for (int i = 0; i < 33; i++) src0.push_back(mk(1'b0, 8'($urandom), 8'hc3));
    repeat (8) cycle();
    stub_en = 1;
    cycle();
    base = acc_cnt + int'(pend0);
    stalls = 0;
    repeat (20) begin
      cycle();
      if (!ch0_ready) stalls++;
    end
    n_checks++;
    if (stalls != 0) $display("FAIL simul_stall: got %0d stalled cycles want 0", stalls);
    else n_pass++;
    n_checks++;
    if (acc_cnt + int'(pend0) - base != 20)
      $display("FAIL simul_accepts: got %0d want 20", acc_cnt + int'(pend0) - base);
    else n_pass++;
    run_until_out(33, 200);
    n_checks++;
    if (out_log.size() != 33) $display("FAIL simul_out_cnt: got %0d want 33", out_log.size());
    else n_pass++;
    for (int i = 0; i < out_log.size() && i < acc_log.size(); i++) begin
      n_checks++;
      if (out_log[i] !== {1'b0, acc_log[i].chr ^ 8'hc3})
        $display("FAIL simul_out[%0d]: got %h want %h", i, out_log[i], {1'b0, acc_log[i].chr ^ 8'hc3});
      else n_pass++;
    end
    n_checks++;
    if (err_tag !== 1'b0) $display("FAIL simul_err: got %b want 0", err_tag);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    stub_en = 0; stub_rand = 0; gap_en = 0;
    for (int i = 0; i < 6; i++) src0.push_back(mk(1'b0, 8'($urandom), 8'h77));
    for (int k = 0; k < 20 && acc_cnt < 2; k++) cycle();
    n_checks++;
    if (acc_cnt != 2) $display("FAIL mid_setup: got %0d accepts want 2", acc_cnt);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ch0_ready, ch1_ready, cph_din_valid, out_valid, out_ch, busy, err_tag} !== 7'b0)
      $display("FAIL mid_reset_ctrl: got %b want 0000000",
               {ch0_ready, ch1_ready, cph_din_valid, out_valid, out_ch, busy, err_tag});
    else n_pass++;
    n_checks++;
    if ({cph_key, cph_char, out_char} !== 24'h0)
      $display("FAIL mid_reset_data: got %h want 000000", {cph_key, cph_char, out_char});
    else n_pass++;
    clear_tb();
    @(negedge clk);
    rst_n = 1'b1;
    stub_en = 1;
    repeat (5) cycle();
    n_checks++;
    if ({out_log.size() != 0, err_tag, busy} !== 3'b000)
      $display("FAIL mid_quiet: got outs=%0d err=%b busy=%b want 0 0 0", out_log.size(), err_tag, busy);
    else n_pass++;
    stray = 1;
    cycle();
    stray = 0;
    cycle();
    n_checks++;
    if (err_tag !== 1'b1) $display("FAIL stray_err: got %b want 1", err_tag);
    else n_pass++;
    repeat (3) cycle();
    n_checks++;
    if ({err_tag, out_log.size() != 0} !== 2'b10)
      $display("FAIL stray_sticky: got err=%b outs=%0d want 1 0", err_tag, out_log.size());
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    stub_en = 0; stub_rand = 0; gap_en = 0; stray = 0; pend0 = 0; pend1 = 0;
    ch0_char = '0; ch0_key = '0; ch1_char = '0; ch1_key = '0;
    clear_tb();
    test_reset();
    test_single();
    test_burst();
    test_interleave_random();
    test_tag_full();
    test_simul_push_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
